neuron_accum: RTL
=================

# neuron_accum

Floating-point dot-product stage that computes one neuron's pre-activation sum Σ(x_i·w_i) over N streamed input/weight pairs. It sits directly upstream of `sigmoid`: its `sum` output drives the sigmoid's `x`, and its `done` pulse is the source for the sigmoid's `start`. Data is IEEE-754 single precision with a reduced-feature arithmetic model, so the RTL stays small and deterministic.

## Interface
- `S`, default 32: data width; only 32 (IEEE-754 single) is supported.
- `N`, default 4: number of (x, w) pairs per neuron; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a new sum; honoured only in IDLE.
- `x_in`  in  S  input activation, float.
- `w_in`  in  S  weight, float.
- `in_valid`  in  1  the `x_in`/`w_in` pair is valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `sum`  out  S  final dot product; held stable from `done` until the next accepted `start`.
- `done`  out  1  one-cycle pulse when `sum` is valid.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: `start` → ACCEPT. Accumulator is cleared to +0, pair counter `cnt` is set to 0, and `sum` is cleared.
  - ACCEPT: `in_ready` = 1. On `in_valid && in_ready`, the pair is registered → MUL.
  - MUL: registers product p = x·w.
  - ADD: acc ← acc + p; `cnt` ← `cnt` + 1. If `cnt` was N−1 → DONE, else → ACCEPT.
  - DONE: `sum` ← acc, `done` = 1 → IDLE.
- Counter width is $clog2(N+1).
- Float rules, applied identically in the multiplier and the adder:
  - Exponent 0 (zero or denormal) is treated as zero; denormal results flush to +0.
  - Exponent 0xFF inputs are treated as ±max finite.
  - Rounding is truncation (toward zero).
  - Overflow saturates to ±0x7F7FFFFF.
  - Exact cancellation gives +0.
  - Product sign is the XOR of the operand signs.
- `start` while busy (including the DONE cycle) is ignored.
- `in_valid` outside ACCEPT is ignored; no pair is consumed.
- `x_in`/`w_in` may change freely while `in_ready` = 0.

## Timing
- Reset values (`rst_n` = 0 at a posedge): state IDLE, `sum` = 0, `done` = 0, `in_ready` = 0, `busy` = 0, `cnt` = 0, acc = 0.
- Reset mid-operation aborts immediately; no `done` is produced.
- `start` sampled at edge t → `in_ready` = 1 from t+1.
- Each accepted pair costs 3 cycles (ACCEPT, MUL, ADD) when `in_valid` is held high.
- Minimum latency from `start` to `done` = 3N + 2 cycles; for N = 4 that is 14.
- `in_valid` low in ACCEPT stalls indefinitely; the state is held.
- `done` is high for exactly one cycle. `sum` is valid on that cycle and afterwards.
- The earliest next `start` is honoured in the cycle after `done`.

## Configuration
- Macro: `NEURON_BIAS_EN`.
- When defined:
  - Adds port `bias`  in  S.
  - `bias` is sampled with `start`, and the accumulator initialises to `bias` instead of +0.
  - Bias saturation follows the same float rules as above.
- When undefined: no `bias` port; the accumulator initialises to +0.

## Structure
- Shared package `nn_fp_pkg` holds:
  - `FP_EXP_W` = 8, `FP_MAN_W` = 23, `FP_EXP_BIAS` = 127.
  - `FP_MAX_POS` = 32'h7F7FFFFF.
  - The `fp_t` packed struct {sign, exp, man}.
  - The FSM state enum.
- One natural sub-module: `fp_add`, a combinational aligned add/subtract with normalise, truncate and saturate.
- The multiplier (24×24 mantissa product, exponent sum) stays inline in `neuron_accum`.

## Test plan
- **Case A**, N=2, no bias: pairs (3F800000, 40000000), (3FC00000, 40000000) → `sum` = 40A00000 (5.0). `done` falls exactly 8 cycles after the `start` edge when `in_valid` is held high.
- **Case B**, N=2: pairs (3FF33333, C0000000), (00000000, 3F800000) → `sum` = C0733333 (−3.8). Also checks zero-flush and sign handling.
- **Case C**, cancellation: N=2, pairs (40000000, 3F800000), (C0000000, 3F800000) → `sum` = 00000000. Overflow: N=1, pair (7F000000, 7F000000) → `sum` = 7F7FFFFF.
- **Case D**, stall and ignore:
  - Drop `in_valid` for 5 cycles mid-stream → the result equals Case A and latency grows by 5.
  - A `start` pulse during ACCEPT, MUL and DONE is ignored; `cnt` is unaffected.
- **Case E**, reset: assert `rst_n` = 0 during MUL → on the next edge all outputs are at reset values and no `done` appears. A following `start` runs Case A cleanly.
- **Case F**, `NEURON_BIAS_EN` defined: `bias` = 3F800000 with the Case A pairs → `sum` = 40C00000 (6.0).

Source files
------------

// File: rtl/nn_fp_pkg.sv
`default_nettype none
// ============================================================================
// nn_fp_pkg : float format constants, fp_t struct, accumulator FSM states
// Rev 1.0
// ============================================================================
package nn_fp_pkg;

    localparam int          FP_EXP_W    = 8;
    localparam int          FP_MAN_W    = 23;
    localparam int          FP_EXP_BIAS = 127;
    localparam logic [31:0] FP_MAX_POS  = 32'h7F7FFFFF;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_MUL    = 3'd2,
        ST_ADD    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Zero/denormal collapse to +0; Inf/NaN are clamped to the largest finite magnitude.
    function automatic fp_t fp_sanitize(input fp_t a);
        fp_t r;
        r = a;
        if (a.exp == '0) begin
            r = '0;
        end else if (a.exp == '1) begin
            r.exp = 8'hFE;
            r.man = '1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
// fp_add : combinational float add/sub, truncating, saturating, flush-to-zero
// Rev 1.0
// ============================================================================
module fp_add
    import nn_fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    fp_t                w_sa, w_sb, w_big, w_small, w_res;
    logic [7:0]         w_d;
    logic [26:0]        w_mb, w_ms_full, w_ms, w_norm;
    logic               w_sticky;
    logic [27:0]        w_s;
    logic [4:0]         w_lz;
    logic signed [9:0]  w_e;
    logic [22:0]        w_man;

    always_comb begin
        w_sa = fp_sanitize(fp_t'(a));
        w_sb = fp_sanitize(fp_t'(b));
        if ({w_sa.exp, w_sa.man} >= {w_sb.exp, w_sb.man}) begin
            w_big   = w_sa;
            w_small = w_sb;
        end else begin
            w_big   = w_sb;
            w_small = w_sa;
        end

        // Three guard bits plus sticky keep subtraction truncating toward zero.
        w_d       = w_big.exp - w_small.exp;
        w_mb      = {1'b1, w_big.man, 3'b000};
        w_ms_full = {1'b1, w_small.man, 3'b000};
        if (w_d >= 8'd27) begin
            w_ms     = '0;
            w_sticky = 1'b1;
        end else begin
            w_ms     = w_ms_full >> w_d;
            w_sticky = |(w_ms_full & ~({27{1'b1}} << w_d));
        end
        w_ms[0] = w_ms[0] | w_sticky;

        if (w_big.sign == w_small.sign) begin
            w_s = {1'b0, w_mb} + {1'b0, w_ms};
        end else begin
            w_s = {1'b0, w_mb - w_ms};
        end

        w_lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (w_s[i]) begin
                w_lz = 5'(26 - i);
            end
        end
        w_norm = w_s[26:0] << w_lz;

        if (w_s[27]) begin
            w_e   = $signed({2'b00, w_big.exp}) + 10'sd1;
            w_man = 23'(w_s >> 4);
        end else begin
            w_e   = $signed({2'b00, w_big.exp}) - $signed({5'b00000, w_lz});
            w_man = 23'(w_norm >> 3);
        end

        w_res = '0;
        if (w_sa.exp == '0) begin
            w_res = w_sb;
        end else if (w_sb.exp == '0) begin
            w_res = w_sa;
        end else if (w_s == '0) begin
            w_res = '0;
        end else if (w_e >= 10'sd255) begin
            w_res      = fp_t'(FP_MAX_POS);
            w_res.sign = w_big.sign;
        end else if (w_e <= 10'sd0) begin
            w_res = '0;
        end else begin
            w_res = {w_big.sign, w_e[7:0], w_man};
        end
        y = w_res;
    end

endmodule
`default_nettype wire

// File: rtl/neuron_accum.sv
`default_nettype none
// ============================================================================
// neuron_accum : streamed float dot product sum(x_i*w_i) over N pairs
// Option macro NEURON_BIAS_EN adds a bias port that seeds the accumulator.
// Rev 1.0
// ============================================================================
module neuron_accum
    import nn_fp_pkg::*;
#(
    parameter int S = 32,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] x_in,
    input  logic [S-1:0] w_in,
`ifdef NEURON_BIAS_EN
    input  logic [S-1:0] bias,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    output logic [S-1:0] sum,
    output logic         done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    state_t            r_state, w_state_next;
    logic [CW-1:0]     r_cnt;
    fp_t               r_x, r_w, r_prod, r_acc, r_sum;
    logic              r_done;
    fp_t               w_ma, w_mb, w_prod, w_acc_init;
    logic [31:0]       w_add;
    logic [47:0]       w_pm;
    logic signed [9:0] w_pe;
    logic [22:0]       w_pman;

`ifdef NEURON_BIAS_EN
    assign w_acc_init = fp_sanitize(fp_t'(bias));
`else
    assign w_acc_init = '0;
`endif

    // Multiplier: 24x24 mantissa product, truncated, with the same edge rules as the adder.
    always_comb begin
        w_ma = fp_sanitize(r_x);
        w_mb = fp_sanitize(r_w);
        w_pm = 48'({1'b1, w_ma.man}) * 48'({1'b1, w_mb.man});
        w_pe = $signed({2'b00, w_ma.exp}) + $signed({2'b00, w_mb.exp}) - 10'(FP_EXP_BIAS);
        if (w_pm[47]) begin
            w_pe   = w_pe + 10'sd1;
            w_pman = 23'(w_pm >> 24);
        end else begin
            w_pman = 23'(w_pm >> 23);
        end
        w_prod = '0;
        if (w_ma.exp == '0 || w_mb.exp == '0) begin
            w_prod = '0;
        end else if (w_pe >= 10'sd255) begin
            w_prod      = fp_t'(FP_MAX_POS);
            w_prod.sign = w_ma.sign ^ w_mb.sign;
        end else if (w_pe <= 10'sd0) begin
            w_prod = '0;
        end else begin
            w_prod = {w_ma.sign ^ w_mb.sign, w_pe[7:0], w_pman};
        end
    end

    fp_add u_fp_add (
        .a (r_acc),
        .b (r_prod),
        .y (w_add)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_MUL;
                end
            end
            ST_MUL:  w_state_next = ST_ADD;
            ST_ADD:  w_state_next = (r_cnt == CW'(N - 1)) ? ST_DONE : ST_ACCEPT;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_x    <= '0;
            r_w    <= '0;
            r_prod <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= w_acc_init;
                        r_cnt <= '0;
                        r_sum <= '0;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        r_x <= fp_t'(x_in);
                        r_w <= fp_t'(w_in);
                    end
                end
                ST_MUL: r_prod <= w_prod;
                ST_ADD: begin
                    r_acc <= fp_t'(w_add);
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_DONE: begin
                    r_sum  <= r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign done = r_done;

endmodule
`default_nettype wire
